io_port_unit: RTL and testbench
===============================

Name: io_port_unit

Overview:
- Buffered I/O adapter on the datapath's external port side.
- Input path: an external valid/ready producer fills an input FIFO. The head word drives the datapath INPUTUnit bus, and the FIFO pops when the control unit asserts INPUTout.
- Output path: busLO is captured into an output FIFO whenever OUTPUTin is asserted. An external valid/ready consumer drains it.
- Result: the processor never stalls on slow I/O, and overflow/underflow are recorded as sticky error flags.

Parameters:
- BITS, 32, data word width; matches the datapath bus width.
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- busLO  input  BITS  datapath low bus; source of output words.
- OUTPUTin  input  1  push busLO into the output FIFO this edge.
- INPUTout  input  1  pop the input FIFO head this edge.
- INPUTUnit  output  BITS  input FIFO head word; 0 when the input FIFO is empty.
- in_data  input  BITS  external input word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  input FIFO can accept a word.
- out_data  output  BITS  output FIFO head word; 0 when empty.
- out_valid  output  1  output FIFO is non-empty.
- out_ready  input  1  external consumer accepts out_data.
- in_count  output  CW  input FIFO occupancy, 0..DEPTH.
- out_count  output  CW  output FIFO occupancy, 0..DEPTH.
- err_clr  input  1  synchronous clear of the sticky error flags.
- ovf_err  output  1  sticky flag: an OUTPUTin push was dropped.
- unf_err  output  1  sticky flag: INPUTout was asserted while the input FIFO was empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - all pointers and counts go to 0; ovf_err=0, unf_err=0.
  - outputs read: INPUTUnit=0, out_data=0, out_valid=0, in_ready=1.
  - FIFO storage contents are don't-care.
  - reset asserted mid-transfer discards all buffered words; no partial state survives.
- Each FIFO is circular storage with rd_ptr/wr_ptr of width CW-1, wrapping DEPTH-1 -> 0, plus a count register. full = (count==DEPTH), empty = (count==0).
- Input FIFO:
  - push = in_valid & in_ready, with in_ready = !in_full. in_ready is registered state only, with no combinational path from INPUTout.
  - When full, a same-cycle INPUTout does not enable a push; in_ready stays 0 that cycle.
  - pop = INPUTout & !in_empty.
  - INPUTout while empty: no pointer change, unf_err set.
  - push and pop in the same cycle: both occur and in_count is unchanged.
- INPUTUnit:
  - equals mem[rd_ptr] when non-empty, else 0; purely a function of registered state.
  - after a pop edge it shows the next word, or 0 if the FIFO is now empty.
  - the datapath INPUT register samples INPUTUnit every cycle, so control must space consecutive INPUTout pulses at least 2 cycles apart. The block does not check this.
- Output FIFO:
  - push = OUTPUTin & (!out_full | (out_valid & out_ready)). When full and the consumer pops in the same cycle, the push is accepted.
  - OUTPUTin while full with no same-cycle pop: the word is dropped, storage is unchanged, ovf_err set.
  - pop = out_valid & out_ready. out_valid = !out_empty; out_data = head word when non-empty, else 0.
  - Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. It appears at the head immediately only if the FIFO was empty.
- Sticky flags:
  - set on their error event and held until an err_clr edge.
  - err_clr and an error event in the same cycle: the flag ends at 1 (set wins).
- Counts update every edge: count + push - pop. They never exceed DEPTH and never go below 0.
- Ordering: strict FIFO order on both paths, including across pointer wrap-around.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> in_count=0, INPUTUnit=0, in_ready=1, out_valid=0, both err flags 0. Release reset -> first in_data is accepted on the next edge.
- Input fill/drain: push 0x11,0x22,0x33,0x44 -> in_ready=0, in_count=4, INPUTUnit=0x11. Then 4 INPUTout pulses 2 cycles apart -> INPUTUnit shows 0x22,0x33,0x44,0 in turn; unf_err stays 0.
- Underflow: INPUTout=1 with the input FIFO empty -> unf_err=1, in_count=0. Pulse err_clr -> unf_err=0.
- Output overflow: out_ready=0; OUTPUTin with busLO=0xA0..0xA4 (5 pushes) -> out_count=4, ovf_err=1. Set out_ready=1 -> out_data sequence 0xA0,0xA1,0xA2,0xA3, then out_valid=0.
- Full push+pop: output FIFO full (0xB0..0xB3); in one cycle OUTPUTin with busLO=0xB4 and out_ready=1 -> out_count stays 4, ovf_err=0. Drain yields 0xB1,0xB2,0xB3,0xB4.
- Wrap and simultaneous operation: stream 10 input words while popping every 2 cycles -> every word arrives at INPUTUnit in order, in_count never exceeds 4. Assert reset mid-stream -> in_count=0, INPUTUnit=0 immediately (asynchronous).

Source files
------------

// File: rtl/io_port_unit.sv
// Buffered I/O adapter: an input FIFO feeds the datapath INPUTUnit bus, and an
// output FIFO captures busLO for an external consumer. Overflow and underflow are sticky.
module io_port_unit #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] busLO,
  input  logic            OUTPUTin,
  input  logic            INPUTout,
  output logic [BITS-1:0] INPUTUnit,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   in_count,
  output logic [CW-1:0]   out_count,
  input  logic            err_clr,
  output logic            ovf_err,
  output logic            unf_err
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [BITS-1:0] in_mem  [DEPTH];
  logic [BITS-1:0] out_mem [DEPTH];
  logic [AW-1:0]   in_rd, in_wr, out_rd, out_wr;
  logic            in_empty, in_push, in_pop, unf_evt;
  logic            out_empty, out_full, out_push, out_pop, ovf_evt;

  always_comb begin
    in_empty  = (in_count == '0);
    in_ready  = (in_count != FULL);
    in_push   = in_valid & in_ready;
    in_pop    = INPUTout & ~in_empty;
    unf_evt   = INPUTout & in_empty;
    INPUTUnit = in_empty ? '0 : in_mem[in_rd];

    out_empty = (out_count == '0);
    out_full  = (out_count == FULL);
    out_valid = ~out_empty;
    out_pop   = out_valid & out_ready;
    // A full FIFO still accepts a push when its head leaves on the same edge.
    out_push  = OUTPUTin & (~out_full | out_pop);
    ovf_evt   = OUTPUTin & ~out_push;
    out_data  = out_empty ? '0 : out_mem[out_rd];
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= in_data;
    if (out_push) out_mem[out_wr] <= busLO;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_rd     <= '0;
      in_wr     <= '0;
      in_count  <= '0;
      out_rd    <= '0;
      out_wr    <= '0;
      out_count <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      if (in_push) in_wr <= in_wr + AW'(1);
      if (in_pop)  in_rd <= in_rd + AW'(1);
      if (in_push && !in_pop)      in_count <= in_count + CW'(1);
      else if (!in_push && in_pop) in_count <= in_count - CW'(1);

      if (out_push) out_wr <= out_wr + AW'(1);
      if (out_pop)  out_rd <= out_rd + AW'(1);
      if (out_push && !out_pop)      out_count <= out_count + CW'(1);
      else if (!out_push && out_pop) out_count <= out_count - CW'(1);

      if (unf_evt)      unf_err <= 1'b1;
      else if (err_clr) unf_err <= 1'b0;
      if (ovf_evt)      ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Bench for io_port_unit: directed scenarios plus random traffic, checked
// against a queue-based model of both FIFOs and the sticky flags.
module tb_io_port_unit;
  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [BITS-1:0] busLO = '0, in_data = '0;
  logic            OUTPUTin = 1'b0, INPUTout = 1'b0, in_valid = 1'b0;
  logic            out_ready = 1'b0, err_clr = 1'b0;
  logic [BITS-1:0] INPUTUnit, out_data;
  logic            in_ready, out_valid, ovf_err, unf_err;
  logic [CW-1:0]   in_count, out_count;

  int tests = 0;
  int fails = 0;

  logic [BITS-1:0] in_q[$];
  logic [BITS-1:0] out_q[$];
  bit m_ovf, m_unf;

  io_port_unit #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .busLO(busLO), .OUTPUTin(OUTPUTin),
    .INPUTout(INPUTout), .INPUTUnit(INPUTUnit), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_count(in_count),
    .out_count(out_count), .err_clr(err_clr), .ovf_err(ovf_err),
    .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] in_head();
    return (in_q.size() != 0) ? in_q[0] : '0;
  endfunction

  function automatic logic [BITS-1:0] out_head();
    return (out_q.size() != 0) ? out_q[0] : '0;
  endfunction

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic cycle();
    bit ia, ip, ue, op, oa, oe, clr;
    logic [BITS-1:0] d_in, d_out;
    if (!reset) begin
      in_q.delete(); out_q.delete(); m_ovf = 0; m_unf = 0;
      @(posedge clk); #1;
      return;
    end
    ia = in_valid && (in_q.size() < DEPTH);
    ip = INPUTout && (in_q.size() > 0);
    ue = INPUTout && (in_q.size() == 0);
    op = out_ready && (out_q.size() > 0);
    oa = OUTPUTin && ((out_q.size() < DEPTH) || op);
    oe = OUTPUTin && !oa;
    clr = err_clr; d_in = in_data; d_out = busLO;
    @(posedge clk); #1;
    if (ip) void'(in_q.pop_front());
    if (ia) in_q.push_back(d_in);
    if (op) void'(out_q.pop_front());
    if (oa) out_q.push_back(d_out);
    if (ue) m_unf = 1; else if (clr) m_unf = 0;
    if (oe) m_ovf = 1; else if (clr) m_ovf = 0;
  endtask

  task automatic idle();
    OUTPUTin = 0; INPUTout = 0; in_valid = 0; out_ready = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 1; in_data = 32'h99; OUTPUTin = 1; busLO = 32'h77;
    cycle(); cycle();
    tests++; if (in_count !== '0) begin fails++; $display("FAIL rst_in_count got %0d exp 0", in_count); end
    tests++; if (INPUTUnit !== '0) begin fails++; $display("FAIL rst_INPUTUnit got %h exp 0", INPUTUnit); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0 || out_data !== '0) begin fails++; $display("FAIL rst_out got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
    tests++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin fails++; $display("FAIL rst_err got ovf=%b unf=%b exp 0 0", ovf_err, unf_err); end
    idle(); reset = 1; in_valid = 1; in_data = 32'h55;
    cycle();
    in_valid = 0;
    tests++; if (in_count !== CW'(1) || INPUTUnit !== 32'h55) begin fails++; $display("FAIL rst_first_accept got cnt=%0d head=%h exp 1 55", in_count, INPUTUnit); end
    INPUTout = 1; cycle(); INPUTout = 0; cycle();
    tests++; if (in_count !== '0 || INPUTUnit !== '0) begin fails++; $display("FAIL rst_drain got cnt=%0d head=%h exp 0 0", in_count, INPUTUnit); end
  endtask

  task automatic test_input_fill();
    logic [BITS-1:0] wr[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [BITS-1:0] rd[4] = '{32'h22, 32'h33, 32'h44, 32'h00};
    idle();
    for (int i = 0; i < 4; i++) begin in_valid = 1; in_data = wr[i]; cycle(); end
    in_valid = 0;
    tests++; if (in_ready !== 1'b0 || in_count !== CW'(4)) begin fails++; $display("FAIL fill_full got rdy=%b cnt=%0d exp 0 4", in_ready, in_count); end
    tests++; if (INPUTUnit !== 32'h11) begin fails++; $display("FAIL fill_head got %h exp 11", INPUTUnit); end
    for (int i = 0; i < 4; i++) begin
      INPUTout = 1; cycle(); INPUTout = 0; cycle();
      tests++; if (INPUTUnit !== rd[i]) begin fails++; $display("FAIL drain_%0d got %h exp %h", i, INPUTUnit, rd[i]); end
    end
    tests++; if (unf_err !== 1'b0) begin fails++; $display("FAIL drain_unf got %b exp 0", unf_err); end
  endtask

  task automatic test_underflow();
    idle();
    INPUTout = 1; cycle(); INPUTout = 0;
    tests++; if (unf_err !== 1'b1 || in_count !== '0) begin fails++; $display("FAIL unf_set got unf=%b cnt=%0d exp 1 0", unf_err, in_count); end
    cycle();
    tests++; if (unf_err !== 1'b1) begin fails++; $display("FAIL unf_sticky got %b exp 1", unf_err); end
    err_clr = 1; INPUTout = 1; cycle(); INPUTout = 0;
    tests++; if (unf_err !== 1'b1) begin fails++; $display("FAIL unf_set_wins got %b exp 1", unf_err); end
    cycle(); err_clr = 0;
    tests++; if (unf_err !== 1'b0) begin fails++; $display("FAIL unf_clr got %b exp 0", unf_err); end
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 0; i < 5; i++) begin OUTPUTin = 1; busLO = 32'hA0 + i; cycle(); end
    OUTPUTin = 0;
    tests++; if (out_count !== CW'(4) || ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_full got cnt=%0d ovf=%b exp 4 1", out_count, ovf_err); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + i) begin fails++; $display("FAIL ovf_drain_%0d got v=%b d=%h exp 1 %h", i, out_valid, out_data, 32'hA0 + i); end
      cycle();
    end
    tests++; if (out_valid !== 1'b0 || out_data !== '0) begin fails++; $display("FAIL ovf_empty got v=%b d=%h exp 0 0", out_valid, out_data); end
    err_clr = 1; cycle(); err_clr = 0;
    tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_clr got %b exp 0", ovf_err); end
  endtask

  task automatic test_full_push_pop();
    idle();
    for (int i = 0; i < 4; i++) begin OUTPUTin = 1; busLO = 32'hB0 + i; cycle(); end
    OUTPUTin = 1; busLO = 32'hB4; out_ready = 1; cycle();
    OUTPUTin = 0; out_ready = 0;
    tests++; if (out_count !== CW'(4) || ovf_err !== 1'b0) begin fails++; $display("FAIL fpp_cnt got cnt=%0d ovf=%b exp 4 0", out_count, ovf_err); end
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      tests++; if (out_data !== 32'hB0 + i) begin fails++; $display("FAIL fpp_drain_%0d got %h exp %h", i, out_data, 32'hB0 + i); end
      cycle();
    end
    out_ready = 0;
  endtask

  task automatic test_wrap_stream();
    int sent = 0, recv = 0, c = 0;
    idle();
    while (recv < 10 && c < 80) begin
      in_valid = (sent < 10); in_data = 32'hC0 + sent;
      INPUTout = (c % 2 == 1);
      if (INPUTout && in_q.size() > 0) begin
        tests++; if (INPUTUnit !== 32'hC0 + recv) begin fails++; $display("FAIL stream_%0d got %h exp %h", recv, INPUTUnit, 32'hC0 + recv); end
        recv++;
      end
      if (in_count > CW'(DEPTH)) begin tests++; fails++; $display("FAIL stream_cnt got %0d exp <=%0d", in_count, DEPTH); end
      if (in_valid && in_q.size() < DEPTH) sent++;
      cycle(); c++;
    end
    idle();
    tests++; if (recv !== 10) begin fails++; $display("FAIL stream_done got %0d exp 10", recv); end
    for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = 32'hD0 + i; cycle(); end
    reset = 0; #1;
    tests++; if (in_count !== '0 || INPUTUnit !== '0) begin fails++; $display("FAIL async_rst got cnt=%0d head=%h exp 0 0", in_count, INPUTUnit); end
    idle(); cycle(); reset = 1;
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1); in_data = $urandom;
      INPUTout = ($urandom_range(0, 2) == 0); OUTPUTin = $urandom_range(0, 1);
      busLO = $urandom; out_ready = $urandom_range(0, 1);
      err_clr = ($urandom_range(0, 7) == 0);
      cycle();
      tests++;
      if (INPUTUnit !== in_head() || in_count !== CW'(in_q.size()) || in_ready !== (in_q.size() < DEPTH) ||
          out_data !== out_head() || out_count !== CW'(out_q.size()) || out_valid !== (out_q.size() > 0) ||
          ovf_err !== m_ovf || unf_err !== m_unf) begin
        fails++;
        $display("FAIL rand_%0d got in=%h/%0d/%b out=%h/%0d/%b err=%b%b exp in=%h/%0d out=%h/%0d err=%b%b",
                 i, INPUTUnit, in_count, in_ready, out_data, out_count, out_valid, ovf_err, unf_err,
                 in_head(), in_q.size(), out_head(), out_q.size(), m_ovf, m_unf);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_input_fill();
    test_underflow();
    test_overflow();
    test_full_push_pop();
    test_wrap_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
